// File: rtl/store_data_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : store_data_queue_pkg
//  Purpose  : Shared constants for the store-data queue: source indices and
//             the NOP select code.
//  Revision : 1.0  initial release
// ============================================================================
package store_data_queue_pkg;

    // Store-data source indices into the packed source bus
    localparam int SRC_REGA = 0;
    localparam int SRC_REGB = 1;
    localparam int SRC_RA   = 2;

    // NOP code for the default 2-bit select; wider selects use all-ones too
    localparam logic [1:0] RAM_DATA_OP_NOP = 2'b11;

endpackage : store_data_queue_pkg
`default_nettype wire

// File: rtl/store_fifo_core.sv
`default_nettype none
// ============================================================================
//  Module   : store_fifo_core
//  Purpose  : Write-buffer storage for queued stores: entry registers, read
//             and write pointers, occupancy count, full/empty flags. Entry
//             contents are exported flat so the parent can run its CAM.
//  Revision : 1.0  initial release
// ============================================================================
module store_fifo_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [ADDR_W-1:0]          head_addr,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [DEPTH*ADDR_W-1:0]    ent_addr,
    output logic [DEPTH*DATA_W-1:0]    ent_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    // Internal guards make push-when-full and pop-when-empty harmless
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    assign count     = r_count;
    assign rd_ptr    = r_rd_ptr;
    assign head_addr = r_mem_addr[r_rd_ptr];
    assign head_data = r_mem_data[r_rd_ptr];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign ent_addr[gi*ADDR_W +: ADDR_W] = r_mem_addr[gi];
            assign ent_data[gi*DATA_W +: DATA_W] = r_mem_data[gi];
        end
    endgenerate

    // Storage, pointers and count; pointers wrap naturally since DEPTH is 2^n
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_addr[i] <= '0;
                r_mem_data[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem_addr[r_wr_ptr] <= push_addr;
                r_mem_data[r_wr_ptr] <= push_data;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : store_fifo_core
`default_nettype wire

// File: rtl/store_data_queue.sv
`default_nettype none
// ============================================================================
//  Module   : store_data_queue
//  Purpose  : Store-data source select with registered hold value, a DEPTH
//             entry write buffer drained to RAM via req/ack, and
//             store-to-load forwarding from the buffered entries.
//  Revision : 1.0  initial release
// ============================================================================
module store_data_queue
    import store_data_queue_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NSRC   = 3,
    parameter int SEL_W  = 2,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NSRC*DATA_W-1:0]     src_data,
    input  logic [SEL_W-1:0]           data_op,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    output logic                       st_ready,
    output logic [DATA_W-1:0]          held_data,
    output logic                       ram_req,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic [DATA_W-1:0]          ram_data,
    input  logic                       ram_ack,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_op
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(DEPTH+1);
    localparam logic [SEL_W-1:0] C_OP_NOP = '1;

    logic [DATA_W-1:0]       w_sel_data;
    logic                    w_legal;
    logic                    w_nop;
    logic                    w_illegal;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [PTR_W-1:0]        w_rd_ptr;
    logic [PTR_W-1:0]        w_idx;
    logic [DEPTH*ADDR_W-1:0] w_ent_addr;
    logic [DEPTH*DATA_W-1:0] w_ent_data;
    logic [DATA_W-1:0]       r_held;
    logic                    r_err;

    assign w_nop     = (data_op == C_OP_NOP);
    assign w_illegal = !w_legal && !w_nop;

    // Source select decode; all-ones stays NOP even if NSRC would cover it
    always_comb begin
        w_sel_data = '0;
        w_legal    = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (data_op == SEL_W'(i) && !w_nop) begin
                w_legal    = 1'b1;
                w_sel_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Held store data loads on legal ops; illegal ops latch a sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_held <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_legal) begin
                r_held <= w_sel_data;
            end
            if (w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign held_data = r_held;
    assign err_op    = r_err;

    // Ready is purely !full, so a same-cycle pop never frees a slot early
    assign st_ready = !w_full;
    assign ram_req  = !w_empty;
    assign w_push   = st_valid && st_ready && w_legal;
    assign w_pop    = ram_ack && ram_req;

    store_fifo_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_addr (st_addr),
        .push_data (w_sel_data),
        .pop       (w_pop),
        .head_addr (ram_addr),
        .head_data (ram_data),
        .count     (count),
        .full      (w_full),
        .empty     (w_empty),
        .rd_ptr    (w_rd_ptr),
        .ent_addr  (w_ent_addr),
        .ent_data  (w_ent_data)
    );

    // Forwarding CAM: walk from oldest to youngest so the last match wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        w_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = w_rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) &&
                (w_ent_addr[w_idx*ADDR_W +: ADDR_W] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = w_ent_data[w_idx*DATA_W +: DATA_W];
            end
        end
    end

endmodule : store_data_queue
`default_nettype wire

// File: tb/tb_store_data_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_data_queue
//  Purpose  : Scoreboard bench for store_data_queue: a reference FIFO of
//             expected stores is filled by the stimulus side and drained by a
//             monitor on each RAM handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_store_data_queue;
    import store_data_queue_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int NS    = 3;
    localparam int SW    = 3;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam logic [SW-1:0] OP_NOP = '1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic              clk;
    logic              rst;
    logic [NS*DW-1:0]  src_data;
    logic [SW-1:0]     data_op;
    logic              st_valid;
    logic [AW-1:0]     st_addr;
    logic              st_ready;
    logic [DW-1:0]     held_data;
    logic              ram_req;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_data;
    logic              ram_ack;
    logic [AW-1:0]     ld_addr;
    logic              fwd_hit;
    logic [DW-1:0]     fwd_data;
    logic [CW-1:0]     count;
    logic              err_op;

    store_data_queue #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NSRC   (NS),
        .SEL_W  (SW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_data  (src_data),
        .data_op   (data_op),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_ready  (st_ready),
        .held_data (held_data),
        .ram_req   (ram_req),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_ack   (ram_ack),
        .ld_addr   (ld_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .count     (count),
        .err_op    (err_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    ent_t          exp_q[$];
    logic [DW-1:0] exp_held = '0;
    logic          exp_err  = 1'b0;
    logic [DW-1:0] srcw [NS];
    bit            mon_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit op_legal(input logic [SW-1:0] op);
        return int'(op) < NS;
    endfunction

    function automatic bit op_illegal(input logic [SW-1:0] op);
        return (int'(op) >= NS) && (op != OP_NOP);
    endfunction

    // Monitor: compare every visible output against the reference queue, and
    // retire the head entry whenever the RAM handshake completes
    always @(negedge clk) begin : mon
        logic          fh;
        logic [DW-1:0] fd;
        if (mon_en) begin
            fh = 1'b0;
            fd = '0;
            foreach (exp_q[i]) begin
                if (exp_q[i].a == ld_addr) begin
                    fh = 1'b1;
                    fd = exp_q[i].d;
                end
            end
            chk("count",    32'(count),     32'(exp_q.size()));
            chk("st_ready", 32'(st_ready),  32'(exp_q.size() < DEPTH));
            chk("ram_req",  32'(ram_req),   32'(exp_q.size() != 0));
            chk("held",     32'(held_data), 32'(exp_held));
            chk("err_op",   32'(err_op),    32'(exp_err));
            chk("fwd_hit",  32'(fwd_hit),   32'(fh));
            chk("fwd_data", 32'(fwd_data),  32'(fd));
            if (exp_q.size() != 0) begin
                chk("ram_addr", 32'(ram_addr), 32'(exp_q[0].a));
                chk("ram_data", 32'(ram_data), 32'(exp_q[0].d));
                if (ram_ack) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; called at posedge+1, returns at next posedge+1
    task automatic cyc(input logic v, input logic [SW-1:0] op, input logic [AW-1:0] a,
                       input logic ack, input logic [AW-1:0] ld);
        bit   acc;
        ent_t e;
        st_valid = v;
        data_op  = op;
        st_addr  = a;
        ram_ack  = ack;
        ld_addr  = ld;
        src_data = {srcw[2], srcw[1], srcw[0]};
        acc      = v && op_legal(op) && (exp_q.size() < DEPTH);
        e.a      = a;
        e.d      = op_legal(op) ? srcw[int'(op)] : '0;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_held = '0;
            exp_err  = 1'b0;
        end else begin
            if (acc) exp_q.push_back(e);
            if (op_legal(op)) exp_held = e.d;
            if (op_illegal(op)) exp_err = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input logic ack);
        cyc(1'b0, OP_NOP, '0, ack, 16'hFFFF);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        st_valid = 1'b0;
        data_op  = OP_NOP;
        st_addr  = '0;
        ram_ack  = 1'b0;
        ld_addr  = '0;
        srcw[SRC_REGA] = 16'h1111;
        srcw[SRC_REGB] = 16'h2222;
        srcw[SRC_RA]   = 16'h3333;
        src_data = '0;
        #1;
        do_reset();
        do_reset();
        mon_en = 1'b1;

        // Reset values
        chk("rst_count",    32'(count),     32'd0);
        chk("rst_ready",    32'(st_ready),  32'd1);
        chk("rst_ram_req",  32'(ram_req),   32'd0);
        chk("rst_ram_addr", 32'(ram_addr),  32'd0);
        chk("rst_ram_data", 32'(ram_data),  32'd0);
        chk("rst_held",     32'(held_data), 32'd0);
        chk("rst_fwd_data", 32'(fwd_data),  32'd0);

        // Single store from REGB appears on the RAM side next cycle
        cyc(1'b1, 3'(SRC_REGB), 16'h0040, 1'b0, 16'h0000);
        chk("t1_ram_req",  32'(ram_req),   32'd1);
        chk("t1_ram_addr", 32'(ram_addr),  32'h0040);
        chk("t1_ram_data", 32'(ram_data),  32'h2222);
        chk("t1_held",     32'(held_data), 32'h2222);
        chk("t1_count",    32'(count),     32'd1);
        idle(1'b1);

        // Fill to DEPTH, fifth store refused even with ack, then drain in order
        for (int i = 0; i < 4; i++) cyc(1'b1, 3'(SRC_REGA), AW'(16'h10 + i), 1'b0, 16'h0);
        chk("full_count", 32'(count),    32'd4);
        chk("full_ready", 32'(st_ready), 32'd0);
        cyc(1'b1, 3'(SRC_RA), 16'h0014, 1'b1, 16'h0);
        chk("full_no_accept", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("drain_count", 32'(count), 32'd0);

        // Youngest matching entry forwards
        srcw[SRC_REGA] = 16'hAAAA;
        cyc(1'b1, 3'(SRC_REGA), 16'h0020, 1'b0, 16'h0);
        srcw[SRC_REGA] = 16'hBBBB;
        cyc(1'b1, 3'(SRC_REGA), 16'h0020, 1'b0, 16'h0);
        ld_addr = 16'h0020;
        #1;
        chk("fwd_hit_20",  32'(fwd_hit),  32'd1);
        chk("fwd_data_20", 32'(fwd_data), 32'hBBBB);
        ld_addr = 16'h0021;
        #1;
        chk("fwd_hit_21",  32'(fwd_hit),  32'd0);
        chk("fwd_data_21", 32'(fwd_data), 32'd0);
        idle(1'b1);
        idle(1'b1);

        // NOP and illegal selects enqueue nothing; illegal sets sticky error
        cyc(1'b1, OP_NOP, 16'h0030, 1'b0, 16'h0);
        chk("nop_count", 32'(count),     32'd0);
        chk("nop_held",  32'(held_data), 32'hBBBB);
        cyc(1'b1, 3'd4, 16'h0031, 1'b0, 16'h0);
        chk("ill_count", 32'(count),  32'd0);
        chk("ill_err",   32'(err_op), 32'd1);
        cyc(1'b1, 3'(SRC_RA), 16'h0032, 1'b1, 16'h0);
        chk("ill_sticky", 32'(err_op), 32'd1);
        idle(1'b1);

        // Sustained enqueue with ack every cycle holds count at one
        for (int i = 0; i < 10; i++) begin
            srcw[SRC_REGB] = DW'(16'h5000 + i);
            cyc(1'b1, 3'(SRC_REGB), AW'(16'h50 + i), 1'b1, 16'h0);
            chk("stream_count", 32'(count), 32'd1);
        end
        idle(1'b1);

        // Reset discards a partially filled queue
        for (int i = 0; i < 3; i++) cyc(1'b1, 3'(SRC_RA), AW'(16'h60 + i), 1'b0, 16'h0);
        chk("pre_rst_count", 32'(count), 32'd3);
        do_reset();
        chk("mid_rst_count",   32'(count),     32'd0);
        chk("mid_rst_ram_req", 32'(ram_req),   32'd0);
        chk("mid_rst_err",     32'(err_op),    32'd0);
        chk("mid_rst_held",    32'(held_data), 32'd0);

        // Random traffic over a small address window for frequent CAM hits
        for (int n = 0; n < 400; n++) begin
            logic [SW-1:0] op;
            for (int s = 0; s < NS; s++) srcw[s] = DW'($urandom);
            op = ($urandom_range(0, 9) < 8) ? SW'($urandom_range(0, NS-1)) : SW'($urandom);
            cyc(1'($urandom_range(0, 1)), op, AW'(16'h100 + $urandom_range(0, 7)),
                1'($urandom_range(0, 2) == 0), AW'(16'h100 + $urandom_range(0, 7)));
        end
        for (int i = 0; i < 6; i++) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_store_data_queue
`default_nettype wire
